// File: rtl/polar_pkg.sv
// Shared LLR types and the shift/negate/symmetric-clamp conversion used by
// the channel front end, the decoder and the benches.
package polar_pkg;

  localparam int LLR_BITS = 8;

  typedef logic signed [LLR_BITS-1:0] llr_t;

  localparam llr_t LLR_MAX = llr_t'((2 ** (LLR_BITS - 1)) - 1);

  // Works at 32 bits so negating the most negative input sample never wraps.
  // The clamp is symmetric: -2^(bits-1) is never returned.
  function automatic logic signed [31:0] llr_sat(input logic signed [31:0] x,
                                                 input int shift,
                                                 input logic negate,
                                                 input int bits);
    logic signed [31:0] s;
    logic signed [31:0] lim;
    s = x >>> shift;
    if (negate) s = -s;
    lim = (32'sd1 <<< (bits - 1)) - 32'sd1;
    if (s > lim) s = lim;
    else if (s < -lim) s = -lim;
    return s;
  endfunction

endpackage

// File: rtl/llr_quantize.sv
// Combinational conversion of one wide channel sample to a decoder LLR.
module llr_quantize
  import polar_pkg::*;
#(
  parameter int IN_BITS = 12,
  parameter int BITS    = 8,
  parameter int SHIFT   = 4,
  parameter int NEGATE  = 1
) (
  input  logic signed [IN_BITS-1:0] in_llr,
  output logic signed [BITS-1:0]    llr
);

  assign llr = BITS'(llr_sat(32'(in_llr), SHIFT, NEGATE != 0, BITS));

endmodule

// File: rtl/polar_llr_frame_buffer.sv
// Collects N converted LLRs per frame into ping-pong banks and presents each
// completed frame in parallel on y with a valid/ready handshake.
module polar_llr_frame_buffer
  import polar_pkg::*;
#(
  parameter int N       = 32,
  parameter int IN_BITS = 12,
  parameter int BITS    = 8,
  parameter int SHIFT   = 4,
  parameter int NEGATE  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [IN_BITS-1:0] in_llr,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [BITS-1:0]    y [N],
  output logic                      frame_err
);

  localparam int CNT_W = $clog2(N);

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_FILLING = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  logic [1:0]             st [2];
  logic                   wr_bank;
  logic                   rd_bank;
  logic [CNT_W-1:0]       wr_cnt;
  logic signed [BITS-1:0] q_p0;
  logic signed [BITS-1:0] mem [2][N];
  logic                   acc;
  logic                   hs;
  logic                   nth;

  llr_quantize #(
    .IN_BITS(IN_BITS),
    .BITS   (BITS),
    .SHIFT  (SHIFT),
    .NEGATE (NEGATE)
  ) u_quant (
    .in_llr(in_llr),
    .llr   (q_p0)
  );

  assign in_ready  = (st[wr_bank] != ST_FULL);
  assign out_valid = (st[rd_bank] == ST_FULL);
  assign acc       = in_valid && in_ready;
  assign hs        = out_valid && out_ready;
  assign nth       = (wr_cnt == CNT_W'(N - 1));

  // A FULL bank is never the write bank, so handshake and write never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      st[0]     <= ST_EMPTY;
      st[1]     <= ST_EMPTY;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_cnt    <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (hs) begin
        st[rd_bank] <= ST_EMPTY;
        rd_bank     <= ~rd_bank;
      end
      if (acc) begin
        if (nth) begin
          st[wr_bank] <= ST_FULL;
          wr_cnt      <= '0;
          wr_bank     <= ~wr_bank;
          frame_err   <= !in_last;
        end else if (in_last) begin
          st[wr_bank] <= ST_EMPTY;
          wr_cnt      <= '0;
          frame_err   <= 1'b1;
        end else begin
          st[wr_bank] <= ST_FILLING;
          wr_cnt      <= wr_cnt + CNT_W'(1);
        end
      end
    end
  end

  // p0 -> bank storage
  always_ff @(posedge clk) begin
    if (acc) mem[wr_bank][wr_cnt] <= q_p0;
  end

  // Bank contents are not reset; masking with out_valid keeps y at zero
  // whenever no frame is being offered, including after reset.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      y[i] = out_valid ? mem[rd_bank][i] : '0;
    end
  end

endmodule

// File: doc/polar_llr_frame_buffer.md
# polar_llr_frame_buffer

Channel-side front end for `polar_decode`. It accepts a serial stream of wide signed channel samples and scales, saturates and sign-converts each one to the decoder's LLR format (0 → positive, 1 → negative). It assembles N samples into a frame and presents each completed frame as a parallel `y[N]` array with a valid/ready handshake. Two ping-pong banks let one frame be collected while the previous frame waits for the decoder.

## Interface
- `N`, 32: frame length, i.e. samples per codeword (power of 2).
- `IN_BITS`, 12: width of the signed input sample.
- `BITS`, 8: width of the signed output LLR, matching `polar_decode` `BITS`.
- `SHIFT`, 4: arithmetic right shift applied before saturation (0..IN_BITS-1).
- `NEGATE`, 1: 1 = output is the negated sample (channel +1 maps to bit 1); 0 = pass-through sign.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `in_llr` and `in_last` are valid this cycle.
- `in_ready` out 1: buffer can accept a sample. A transfer happens when `in_valid && in_ready`.
- `in_llr` in IN_BITS, signed: channel sample.
- `in_last` in 1: marks the last sample of a frame.
- `out_valid` out 1: `y` holds a complete frame.
- `out_ready` in 1: the consumer takes the frame when `out_valid && out_ready`.
- `y` out `[N]` x BITS, signed: frame LLRs, with index = sample arrival order.
- `frame_err` out 1: one-cycle pulse when frame alignment fails.

## Operation
- Per-sample conversion, all combinational before the bank write:
  - `s = in_llr >>> SHIFT`.
  - If `NEGATE`, `s = -s`. Compute at IN_BITS+1 width so that negating the minimum value cannot overflow.
  - Clamp `s` to the symmetric range ±(2^(BITS-1)-1). -2^(BITS-1) is never produced.
- Write side:
  - `wr_bank` (1 bit) and `wr_cnt` (log2 N bits) track where the next sample goes.
  - Each accepted sample is written to `bank[wr_bank][wr_cnt]`, then `wr_cnt` increments.
  - On the Nth sample (`wr_cnt == N-1`), the bank is marked full, `wr_cnt` returns to 0 and `wr_bank` toggles.
- Frame alignment:
  - `in_last` on the Nth sample is normal.
  - `in_last` before the Nth sample: the partial frame is discarded, `wr_cnt` returns to 0, `wr_bank` is unchanged, and `frame_err` pulses.
  - Nth sample without `in_last`: the frame is still completed and marked full, and `frame_err` pulses.
- Read side:
  - `rd_bank` selects which bank drives `y`, and `out_valid = full[rd_bank]`.
  - On an `out_valid && out_ready` handshake, `full[rd_bank]` is cleared and `rd_bank` toggles.
- `in_ready = !full[wr_bank]`, i.e. deasserted only when both banks are full.
- Per-bank state machine:
  - EMPTY → FILLING on the first write to the bank.
  - FILLING → FULL on the Nth write.
  - FILLING → EMPTY on an early `in_last`.
  - FULL → EMPTY on the output handshake.

## Timing
- Reset values: `out_valid=0`, `in_ready=1`, `frame_err=0`, `y` all 0. Also `wr_bank=rd_bank=0`, `wr_cnt=0`, both banks EMPTY.
- Reset mid-frame or while a frame is pending drops all stored data. No `out_valid` is produced for dropped data.
- Latency: Nth sample accepted at edge t → `out_valid=1` from cycle t+1.
- `y` is stable while `out_valid=1` and is not overwritten until the handshake completes.
- `out_valid` stays high until accepted. There is no timeout.
- Simultaneous output handshake and Nth write to the other bank: both take effect. `out_valid` remains 1 next cycle and shows the new frame.
- Simultaneous handshake while both banks are full: `in_ready` rises the next cycle. There is no combinational path from `out_ready` to `in_ready`.
- Sustained throughput: one sample per cycle, with no bubbles between frames, provided the consumer accepts each frame within N cycles.
- `frame_err` is registered. It pulses in the cycle after the offending sample.

## Structure
- Shared package `polar_pkg` holds:
  - the `llr_t` typedef, signed [BITS-1:0];
  - the `llr_sat` function (shift, negate, symmetric clamp);
  - the `LLR_MAX` constant.
- `polar_decode` and the test benches reuse these from the same package.
- One natural sub-module, `llr_quantize`: the combinational shift/negate/saturate step, instantiated once on the input path.
- Integration: a top-level wrapper generates `polar_decode.in_valid` from the `out_valid && out_ready` handshake. It also drives `out_ready` from the decoder's idle state.

## Test plan
- **Conversion limits.** N=32, SHIFT=4, NEGATE=1. Feed 32 samples of +160, then repeat with samples of -2048. Required: first frame has y all -10; second frame has y all +127 (saturated); frame_err=0.
- **Ping-pong backpressure.** Hold `out_ready=0` and stream 64 samples. Required: `in_ready` drops after sample 64, and the first frame stays on `y` unchanged. Then raise `out_ready` for one cycle. Required: `y` switches to frame 2 and `in_ready` returns to 1 the next cycle.
- **Early last.** Assert `in_last` on sample 10. Required: `frame_err` pulses once and no `out_valid`. The next 32 samples form a correct frame.
- **Missing last.** Send 32 samples with `in_last=0`. Required: `out_valid` asserts and `frame_err` pulses once.
- **Mid-frame reset.** Assert `rst` after 20 samples. Required: all outputs return to reset values; a following full frame decodes correctly.
- **End-to-end loopback.** Random bits through `polar_transform` → BPSK at SNR 10 dB → this block (NEGATE=1) → `polar_decode` with an all-zero frozen mask, over 10 blocks. Required: 0 bit errors.
